keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a low column across the keypad each scan tick,
// debounces presses and releases over DEB_TICKS ticks, and reports col_idx*4 + row_idx.
module keypad_scanner #(
  parameter int SCAN_DIV  = 250000,
  parameter int DEB_TICKS = 2
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DebW = $clog2(DEB_TICKS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEB_TICKS);
  localparam logic [DebW-1:0] DebOne = DebW'(1);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e          state;
  logic [3:0]      row_meta;
  logic [3:0]      rs;
  logic [CntW-1:0] tick_cnt;
  logic            tick;
  logic [1:0]      col_idx;
  logic [3:0]      sample;
  logic [DebW-1:0] deb_cnt;
  logic [DebW-1:0] rel_cnt;
  logic            rs_idle;

  // Bit 0 wins when several rows of the driven column are low together.
  function automatic logic [1:0] low_idx(input logic [3:0] s);
    if (!s[0])      return 2'd0;
    else if (!s[1]) return 2'd1;
    else if (!s[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      row_meta <= 4'hf;
      rs       <= 4'hf;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick    = (tick_cnt == CntMax);
  assign rs_idle = (rs == 4'hf);
  assign col     = ~(4'b0001 << col_idx);

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state     <= StScan;
      col_idx   <= 2'd0;
      sample    <= 4'hf;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          StScan: begin
            if (!rs_idle) begin
              sample  <= rs;
              deb_cnt <= DebOne;
              if (DEB_TICKS <= 1) begin
                state     <= StPressed;
                key_code  <= {col_idx, low_idx(rs)};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                rel_cnt   <= '0;
              end else begin
                state <= StDebounce;
              end
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end
          StDebounce: begin
            if (rs_idle) begin
              state   <= StScan;
              deb_cnt <= '0;
            end else if (rs == sample) begin
              if (deb_cnt >= DebMax - DebOne) begin
                deb_cnt   <= DebMax;
                state     <= StPressed;
                key_code  <= {col_idx, low_idx(sample)};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                rel_cnt   <= '0;
              end else begin
                deb_cnt <= deb_cnt + DebOne;
              end
            end else begin
              sample  <= rs;
              deb_cnt <= DebOne;
            end
          end
          StPressed: begin
            if (rs_idle) begin
              if (DEB_TICKS <= 1) begin
                state    <= StScan;
                key_held <= 1'b0;
                col_idx  <= col_idx + 2'd1;
                rel_cnt  <= '0;
                deb_cnt  <= '0;
              end else begin
                state   <= StRelease;
                rel_cnt <= DebOne;
              end
            end
          end
          StRelease: begin
            if (rs_idle) begin
              if (rel_cnt >= DebMax - DebOne) begin
                state    <= StScan;
                key_held <= 1'b0;
                col_idx  <= col_idx + 2'd1;
                rel_cnt  <= '0;
                deb_cnt  <= '0;
              end else begin
                rel_cnt <= rel_cnt + DebOne;
              end
            end else begin
              // Release bounce: back to held without a fresh key_valid.
              state   <= StPressed;
              rel_cnt <= '0;
            end
          end
          default: state <= StScan;
        endcase
      end
    end
  end

endmodule
